// File: rtl/button_event_scheduler.sv
// button_event_scheduler
//   Turns raw, asynchronous push-button lines into qualified press/release
//   events. Each line is synchronised (3 flops) and debounced by a
//   stability counter that only advances on a slow sample tick. Qualified
//   level changes are parked in a per-input pending store and handed out
//   one at a time through a round-robin arbiter on a valid/ready port.
//
//   Ports
//     clk        system clock, rising edge
//     rst        asynchronous, active-high reset
//     btn_in     raw button lines (active high, asynchronous)
//     btn_level  debounced level per input
//     evt_valid  event available on evt_id / evt_press
//     evt_ready  consumer accepts when evt_valid && evt_ready at a clock edge
//     evt_id     index of the input that produced the event
//     evt_press  1 = press (0->1), 0 = release (1->0)
//     ovf        sticky: a pending event was overwritten before delivery
//     ovf_clr    synchronous clear of ovf (a same-cycle set wins)
module button_event_scheduler #(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10,
    localparam int ID_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_press,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [TW-1:0]   TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0]   STABLE_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [ID_W-1:0] ID_LAST     = ID_W'(N_BTN - 1);

    logic [N_BTN-1:0] sync1_q, sync2_q, sync3_q;
    logic [TW-1:0]    tick_cnt_q;
    logic             tick;
    logic [SW-1:0]    stab_cnt_q [N_BTN];
    logic [SW-1:0]    stab_cnt_d [N_BTN];
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] qualify;
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] dir_q, dir_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]  evt_id_q, evt_id_d;
    logic             evt_press_q, evt_press_d;
    logic             ovf_q, ovf_d;
    logic             load;
    logic             grant_any;
    logic             grant;
    logic [ID_W-1:0]  grant_id;

    assign tick = (tick_cnt_q == TICK_LAST);

    // Debounce: a new level is accepted only after STABLE_TICKS consecutive
    // ticks disagreeing with the current level; any agreeing tick restarts.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        level_d    = level_q;
        qualify    = '0;
        if (tick) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync3_q[i] == level_q[i]) begin
                    stab_cnt_d[i] = '0;
                end else if (stab_cnt_q[i] == STABLE_LAST) begin
                    level_d[i]    = sync3_q[i];
                    stab_cnt_d[i] = '0;
                    qualify[i]    = 1'b1;
                end else begin
                    stab_cnt_d[i] = stab_cnt_q[i] + SW'(1);
                end
            end
        end
    end

    // Round robin: scan starts one past the last winner and wraps.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = ptr_q;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_BTN) begin
                idx = idx - N_BTN;
            end
            if (!grant_any && pend_q[idx]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    assign load  = !evt_valid_q || evt_ready;
    assign grant = load && grant_any;

    always_comb begin
        pend_d      = pend_q;
        dir_d       = dir_q;
        ptr_d       = ptr_q;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_press_d = evt_press_q;
        ovf_d       = ovf_q;

        if (load) begin
            if (grant_any) begin
                evt_valid_d      = 1'b1;
                evt_id_d         = grant_id;
                evt_press_d      = dir_q[grant_id];
                pend_d[grant_id] = 1'b0;
                ptr_d            = grant_id;
            end else begin
                evt_valid_d = 1'b0;
            end
        end

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        // A fresh qualification re-arms the slot even if the old event is
        // leaving this cycle; only an undelivered event counts as lost.
        for (int i = 0; i < N_BTN; i++) begin
            if (qualify[i]) begin
                if (pend_q[i] && !(grant && (grant_id == ID_W'(i)))) begin
                    ovf_d = 1'b1;
                end
                pend_d[i] = 1'b1;
                dir_d[i]  = level_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            tick_cnt_q  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                stab_cnt_q[i] <= '0;
            end
            level_q     <= '0;
            pend_q      <= '0;
            dir_q       <= '0;
            ptr_q       <= ID_LAST;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_press_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            sync1_q     <= btn_in;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            tick_cnt_q  <= tick ? '0 : tick_cnt_q + TW'(1);
            stab_cnt_q  <= stab_cnt_d;
            level_q     <= level_d;
            pend_q      <= pend_d;
            dir_q       <= dir_d;
            ptr_q       <= ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_press_q <= evt_press_d;
            ovf_q       <= ovf_d;
        end
    end

    assign btn_level = level_q;
    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_press = evt_press_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler with N_BTN=4, TICK_DIV=4,
// STABLE_TICKS=3. Tick edges fall on every 4th rising edge after reset
// release; a change becomes visible to the debouncer 3 edges after it is
// driven and is accepted on the 3rd tick edge after that.
module tb_button_event_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_in = '0;
    logic [3:0] btn_level;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [1:0] evt_id;
    logic       evt_press;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc;

    int ev_n = 0;
    int valid_cnt = 0;
    int ev_id    [256];
    int ev_press [256];
    int ev_edge  [256];

    button_event_scheduler #(
        .N_BTN        (4),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_press (evt_press),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Records every accepted event with the edge number it was taken on.
    always @(posedge clk) begin
        if (!rst) begin
            if (evt_valid) valid_cnt <= valid_cnt + 1;
            if (evt_valid && evt_ready && ev_n < 256) begin
                ev_id[ev_n]    <= int'(evt_id);
                ev_press[ev_n] <= int'(evt_press);
                ev_edge[ev_n]  <= cyc + 1;
                ev_n           <= ev_n + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input int idx, input logic val, output int edge_at);
        int n;
        n = 0;
        edge_at = -1;
        while (btn_level[idx] !== val && n < 60) begin
            step();
            n++;
        end
        if (btn_level[idx] === val) edge_at = cyc;
        check($sformatf("wait_level%0d", idx), 32'(btn_level[idx]), 32'(val));
    endtask

    // Edge on which a change driven just after edge c0 is accepted after nt ticks.
    function automatic int qual_edge(input int c0, input int nt);
        int e;
        int t;
        e = c0 + 3;
        t = 0;
        while (t < nt) begin
            e++;
            if (e % 4 == 0) t++;
        end
        return e;
    endfunction

    initial begin
        int c0;
        int e;
        int exp_e;
        int base;
        int vc0;
        int n;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_valid", 32'(evt_valid), 32'h0);
        check("rst_id",    32'(evt_id),    32'h0);
        check("rst_press", 32'(evt_press), 32'h0);
        check("rst_ovf",   32'(ovf),       32'h0);
        evt_ready = 1'b1;
        step();
        step();

        // ---------------- clean press / release ----------------
        btn_in[0] = 1'b1;
        c0 = cyc;
        exp_e = qual_edge(c0, 3);
        wait_level(0, 1'b1, e);
        check("press_edge", 32'(e), 32'(exp_e));
        check("press_valid_lag", 32'(evt_valid), 32'h0);
        step();
        check("press_valid", 32'(evt_valid), 32'h1);
        check("press_id",    32'(evt_id),    32'h0);
        check("press_dir",   32'(evt_press), 32'h1);
        step();
        check("press_one_cycle", 32'(evt_valid), 32'h0);

        btn_in[0] = 1'b0;
        c0 = cyc;
        exp_e = qual_edge(c0, 3);
        wait_level(0, 1'b0, e);
        check("release_edge", 32'(e), 32'(exp_e));
        step();
        check("release_valid", 32'(evt_valid), 32'h1);
        check("release_id",    32'(evt_id),    32'h0);
        check("release_dir",   32'(evt_press), 32'h0);
        step();
        check("release_one_cycle", 32'(evt_valid), 32'h0);

        // ---------------- bounce rejection ----------------
        vc0 = valid_cnt;
        for (int r = 0; r < 5; r++) begin
            btn_in[1] = 1'b1;
            repeat (8) step();
            btn_in[1] = 1'b0;
            repeat (8) step();
        end
        check("bounce_level", 32'(btn_level[1]), 32'h0);
        check("bounce_no_evt", 32'(valid_cnt), 32'(vc0));
        check("bounce_ovf", 32'(ovf), 32'h0);

        // ---------------- round robin ----------------
        base = ev_n;
        btn_in[1] = 1'b1;
        btn_in[2] = 1'b1;
        wait_level(1, 1'b1, e);
        check("rr1_level", 32'(btn_level), 32'h6);
        repeat (3) step();
        check("rr1_count", 32'(ev_n - base), 32'd2);
        check("rr1_first",  32'(ev_id[base]),     32'd1);
        check("rr1_second", 32'(ev_id[base + 1]), 32'd2);
        check("rr1_b2b", 32'(ev_edge[base + 1] - ev_edge[base]), 32'd1);

        base = ev_n;
        btn_in[0] = 1'b1;
        btn_in[1] = 1'b0;
        btn_in[3] = 1'b1;
        wait_level(3, 1'b1, e);
        check("rr2_level", 32'(btn_level), 32'hD);
        repeat (4) step();
        check("rr2_count", 32'(ev_n - base), 32'd3);
        check("rr2_id0", 32'(ev_id[base]),     32'd3);
        check("rr2_id1", 32'(ev_id[base + 1]), 32'd0);
        check("rr2_id2", 32'(ev_id[base + 2]), 32'd1);
        check("rr2_dir2", 32'(ev_press[base + 2]), 32'd0);

        btn_in = '0;
        repeat (30) step();
        check("drain_level", 32'(btn_level), 32'h0);
        check("drain_valid", 32'(evt_valid), 32'h0);

        // ---------------- backpressure and overflow ----------------
        evt_ready = 1'b0;
        btn_in[0] = 1'b1;
        wait_level(0, 1'b1, e);
        step();
        check("bp_valid", 32'(evt_valid), 32'h1);
        check("bp_id",    32'(evt_id),    32'h0);
        check("bp_dir",   32'(evt_press), 32'h1);

        btn_in[0] = 1'b0;
        wait_level(0, 1'b0, e);
        check("bp_hold_id",  32'(evt_id),    32'h0);
        check("bp_hold_dir", 32'(evt_press), 32'h1);
        check("bp_no_ovf",   32'(ovf),       32'h0);

        btn_in[0] = 1'b1;
        wait_level(0, 1'b1, e);
        check("bp_ovf_set",   32'(ovf),       32'h1);
        check("bp_hold_dir2", 32'(evt_press), 32'h1);

        base = ev_n;
        evt_ready = 1'b1;
        step();
        check("bp_next_valid", 32'(evt_valid), 32'h1);
        check("bp_next_id",    32'(evt_id),    32'h0);
        check("bp_next_dir",   32'(evt_press), 32'h1);
        step();
        check("bp_done_valid", 32'(evt_valid), 32'h0);
        check("bp_count", 32'(ev_n - base), 32'd2);
        check("bp_first_dir", 32'(ev_press[base]), 32'd1);
        check("bp_ovf_sticky", 32'(ovf), 32'h1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 32'h0);

        // ---------------- async reset mid-operation ----------------
        btn_in[3] = 1'b1;
        wait_level(3, 1'b1, e);
        step();
        step();
        evt_ready = 1'b0;
        btn_in[0] = 1'b0;
        wait_level(0, 1'b0, e);
        step();
        btn_in[0] = 1'b1;
        wait_level(0, 1'b1, e);
        btn_in[0] = 1'b0;
        wait_level(0, 1'b0, e);
        check("ar_ovf_pre", 32'(ovf), 32'h1);

        btn_in[2] = 1'b1;
        c0 = cyc;
        exp_e = qual_edge(c0, 2);
        n = 0;
        while (cyc < exp_e && n < 40) begin
            step();
            n++;
        end
        check("ar_two_ticks_edge", 32'(cyc), 32'(exp_e));
        #3;
        check("ar_level_pre", 32'(btn_level), 32'h8);
        check("ar_valid_pre", 32'(evt_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(evt_valid), 32'h0);
        check("ar_level", 32'(btn_level), 32'h0);
        check("ar_ovf",   32'(ovf),       32'h0);
        btn_in[0] = 1'b1;
        evt_ready = 1'b1;
        #1 rst = 1'b0;

        base = ev_n;
        n = 0;
        while (btn_level === 4'h0 && n < 40) begin
            step();
            n++;
        end
        check("ar_requal_edge", 32'(cyc), 32'(qual_edge(0, 3)));
        check("ar_requal_level", 32'(btn_level), 32'hD);
        repeat (4) step();
        check("ar_count", 32'(ev_n - base), 32'd3);
        check("ar_first",  32'(ev_id[base]),     32'd0);
        check("ar_second", 32'(ev_id[base + 1]), 32'd2);
        check("ar_third",  32'(ev_id[base + 2]), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Multi-input front end that turns raw, asynchronous push-button lines into qualified press/release events for the SPI command logic.
- Per input: 3-flop synchronizer, then a tick-sampled stability counter for true debouncing.
- A round-robin scheduler shares a single event output port, with valid/ready handshake, among all inputs.
- Sits between the board button pins and the SPI transaction sequencer.

Parameters:
- N_BTN, 4, number of button inputs (1..16).
- TICK_DIV, 50000, clk cycles per sample tick (1 ms at 50 MHz); minimum 2.
- STABLE_TICKS, 10, consecutive disagreeing ticks required to accept a new level; minimum 1.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- btn_in  in  N_BTN  raw button lines, active-high, asynchronous to clk.
- btn_level  out  N_BTN  debounced level per input.
- evt_valid  out  1  event available on evt_id/evt_press.
- evt_ready  in  1  consumer accepts event when evt_valid && evt_ready at a rising edge.
- evt_id  out  clog2(N_BTN) (min 1)  index of the input that generated the event.
- evt_press  out  1  1 = press (level went 0->1), 0 = release (1->0).
- ovf  out  1  sticky: an event was overwritten while still pending.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-high (clk, rst).
  - While rst=1, all registers clear immediately, no clock needed: sync flops, tick counter, stability counters, pending/dir bits, btn_level=0, evt_valid=0, evt_id=0, evt_press=0, ovf=0, round-robin pointer=N_BTN-1 (input 0 has first priority).
  - Pending events and any event in flight are discarded.
- Synchronizer: each btn_in passes through 3 flops; syn[i] is the third flop output.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is high for exactly one cycle, when count==TICK_DIV-1.
- Stability counter per input, updated only on tick; holds between ticks:
  - syn[i]==btn_level[i]: counter <= 0.
  - syn[i]!=btn_level[i] and counter==STABLE_TICKS-1: btn_level[i] <= syn[i], counter <= 0, qualify[i]=1 this cycle.
  - Otherwise: counter <= counter+1.
  - Glitches between ticks are invisible by design.
- Pending store, per input pend[i] and dir[i]:
  - On qualify[i]: pend[i] <= 1, dir[i] <= new level.
  - If pend[i] was already 1 and is not being granted in the same cycle: ovf <= 1 and dir is overwritten with the newest level.
  - Simultaneous qualify[i] and grant of i: the old event goes out, pend[i] stays 1 with the new dir, ovf unchanged.
- Output register and arbiter:
  - Load condition: evt_valid==0, or (evt_valid && evt_ready).
  - When the load condition holds and any pend bit is set: search starts at pointer+1 modulo N_BTN; the first set bit j wins.
  - On grant: evt_id <= j, evt_press <= dir[j], evt_valid <= 1, pend[j] <= 0, pointer <= j.
  - Load condition with no pend bit set: evt_valid <= 0.
  - While evt_valid && !evt_ready, evt_id and evt_press are held stable.
  - Back-to-back events are possible every cycle while evt_ready=1.
- Latency:
  - qualify at edge T gives evt_valid at edge T+1 earliest.
  - btn_level and the pend bit update on the same edge.
  - Total raw edge to event: 3 cycles of sync plus up to STABLE_TICKS ticks, plus 1 cycle.
- ovf: set beats ovf_clr in the same cycle.

Test Plan:
- Use N_BTN=4, TICK_DIV=4, STABLE_TICKS=3 for all scenarios.
- Clean press: btn_in[0] 0->1 and held, evt_ready=1 -> btn_level[0] rises on the 3rd tick after syn[0] goes high. One cycle later evt_valid=1 for exactly 1 cycle with evt_id=0, evt_press=1. A later release gives evt_press=0.
- Bounce rejection: btn_in[1] high for 2 ticks, then low, repeated 5 times -> btn_level[1] stays 0, evt_valid never asserts, ovf=0.
- Round robin: btn_in[1] and btn_in[2] qualify on the same tick with evt_ready=1 -> events id 1 then id 2 on consecutive cycles. Then inputs 0, 1, 3 qualify together -> order is 3, 0, 1.
- Backpressure and overflow:
  - Stimulus: evt_ready=0; btn0 press qualifies; btn0 release then qualifies while the press event is held.
  - Response: evt_id=0/evt_press=1 stable throughout; pend[0] holds release; ovf=0 so far.
  - Stimulus: a third change on btn0 while still stalled.
  - Response: ovf=1.
  - Stimulus: evt_ready=1.
  - Response: the held event is delivered, followed by one event carrying the latest dir.
  - Stimulus: ovf_clr.
  - Response: ovf=0.
- Async reset mid-operation: rst pulsed between clock edges while evt_valid=1 and a stability counter is at 2 -> evt_valid, btn_level, and ovf go 0 immediately. After release, the held button needs a full 3 ticks to requalify, and input 0 has first priority.
